cic_decimator: RTL and testbench

// - Runtime-programmable N-stage CIC decimator; sits directly upstream of the compensating FIR in the rx chain.
// - Takes strobed ADC/mixer samples, decimates by `rate`, and emits strobed 24-bit samples sized for the FIR input.
// - Output is gain-normalised by bit selection to OUT_WIDTH = IN_WIDTH + 8 for power-of-two rates.

---
 rtl/cic_decimator.sv | 157 +++++++++++++++
 tb/tb_cic_decimator.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cic_decimator.sv
// Runtime-programmable N-stage CIC decimator with power-of-two gain normalisation.
// Define CIC_ROUND_EN for round-half-up with saturation; default build truncates.
module cic_decimator #(
  parameter  int STAGES     = 5,
  parameter  int MAX_RATE   = 64,
  parameter  int IN_WIDTH   = 16,
  parameter  int OUT_WIDTH  = 24,
  localparam int ACC_WIDTH  = IN_WIDTH + STAGES * $clog2(MAX_RATE),
  localparam int RATE_WIDTH = $clog2(MAX_RATE + 1)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [RATE_WIDTH-1:0] rate,
  input  logic                  in_strobe,
  input  logic [IN_WIDTH-1:0]   in_data,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic                  out_strobe,
  output logic                  overrun
);

  localparam int SW = (STAGES > 1) ? $clog2(STAGES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    COMB,
    OUTPUT
  } state_t;

  state_t                       state;
  logic [RATE_WIDTH-1:0]        eff_rate;
  logic [RATE_WIDTH-1:0]        rate_q;
  logic [RATE_WIDTH-1:0]        count;
  logic [SW-1:0]                stage;
  logic                         dec_pend;
  logic                         dec_strobe;
  logic                         rate_change;
  logic signed [ACC_WIDTH-1:0]  integ  [STAGES];
  logic signed [ACC_WIDTH-1:0]  comb_d [STAGES];
  logic signed [ACC_WIDTH-1:0]  work;
  int unsigned                  log2_rate;
  int unsigned                  full_width;
  logic [OUT_WIDTH-1:0]         scaled;

  always_comb begin
    if (rate < RATE_WIDTH'(2))
      eff_rate = RATE_WIDTH'(2);
    else if (rate > RATE_WIDTH'(MAX_RATE))
      eff_rate = RATE_WIDTH'(MAX_RATE);
    else
      eff_rate = rate;
  end

  assign rate_change = (eff_rate != rate_q);
  assign dec_strobe  = in_strobe && (count == rate_q - 1'b1);

  always_comb begin
    log2_rate = 0;
    for (int unsigned i = 0; i < RATE_WIDTH; i++)
      if ((32'd1 << i) < 32'(rate_q)) log2_rate = i + 1;
    full_width = IN_WIDTH + STAGES * log2_rate;
  end

`ifdef CIC_ROUND_EN
  localparam logic [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  logic [OUT_WIDTH:0] wide;

  // wide keeps one extra LSB below the output window; that bit is the rounding increment
  always_comb begin
    wide   = '0;
    scaled = '0;
    if (full_width > OUT_WIDTH) begin
      wide   = (OUT_WIDTH + 1)'(work >>> (full_width - OUT_WIDTH - 1));
      scaled = wide[OUT_WIDTH:1];
      if (wide[0] && scaled != OUT_MAX) scaled = scaled + 1'b1;
    end else if (full_width == OUT_WIDTH) begin
      scaled = OUT_WIDTH'(work);
    end else begin
      scaled = OUT_WIDTH'(work << (OUT_WIDTH - full_width));
    end
  end
`else
  always_comb begin
    scaled = '0;
    if (full_width >= OUT_WIDTH)
      scaled = OUT_WIDTH'(work >>> (full_width - OUT_WIDTH));
    else
      scaled = OUT_WIDTH'(work << (OUT_WIDTH - full_width));
  end
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        integ[k]  <= '0;
        comb_d[k] <= '0;
      end
      work       <= '0;
      count      <= '0;
      stage      <= '0;
      dec_pend   <= 1'b0;
      state      <= IDLE;
      rate_q     <= eff_rate;
      out_data   <= '0;
      out_strobe <= 1'b0;
      overrun    <= 1'b0;
    end else if (rate_change) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        integ[k]  <= '0;
        comb_d[k] <= '0;
      end
      work       <= '0;
      count      <= '0;
      stage      <= '0;
      dec_pend   <= 1'b0;
      state      <= IDLE;
      rate_q     <= eff_rate;
      out_strobe <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      out_strobe <= 1'b0;
      if (in_strobe) begin
        integ[0] <= integ[0] + ACC_WIDTH'($signed(in_data));
        for (int unsigned k = 1; k < STAGES; k++)
          integ[k] <= integ[k] + integ[k-1];
        count <= dec_strobe ? '0 : count + 1'b1;
        // dec_pend marks IDLE waiting to capture; a decimating strobe then is impossible for rate >= 2
        if (dec_strobe) begin
          if (state == IDLE && !dec_pend) dec_pend <= 1'b1;
          else                            overrun  <= 1'b1;
        end
      end
      case (state)
        IDLE: begin
          if (dec_pend) begin
            work     <= integ[STAGES-1];
            dec_pend <= 1'b0;
            stage    <= '0;
            state    <= COMB;
          end
        end
        COMB: begin
          work          <= work - comb_d[stage];
          comb_d[stage] <= work;
          if (stage == SW'(STAGES - 1)) state <= OUTPUT;
          else                          stage <= stage + 1'b1;
        end
        OUTPUT: begin
          out_data   <= scaled;
          out_strobe <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cic_decimator.sv
// Scoreboard bench for cic_decimator: directed DC vectors with hand-derived outputs.
module tb_cic_decimator;

`ifdef CIC_ROUND_EN
  localparam int RND = 1;
`else
  localparam int RND = 0;
`endif

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [6:0]  rate = 7'd8;
  logic        in_strobe = 1'b0;
  logic [15:0] in_data = '0;
  logic [23:0] out_data;
  logic        out_strobe;
  logic        overrun;

  cic_decimator #(
    .STAGES(5),
    .MAX_RATE(64),
    .IN_WIDTH(16),
    .OUT_WIDTH(24)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .rate(rate),
    .in_strobe(in_strobe),
    .in_data(in_data),
    .out_data(out_data),
    .out_strobe(out_strobe),
    .overrun(overrun)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit skip;
    int val;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_mis = 0;
  int   n_out = 0;
  int   cyc = 0;
  int   last_out_cyc = -1000;
  int   min_gap = 1000;
  bit   sb_on = 1'b1;

  always @(posedge clock) cyc++;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int v);
    exp_t e;
    e.skip = 1'b0;
    e.val  = v;
    sb_q.push_back(e);
  endtask

  task automatic push_skip(input int n);
    exp_t e;
    e.skip = 1'b1;
    e.val  = 0;
    for (int i = 0; i < n; i++) sb_q.push_back(e);
  endtask

  // rate 8, DC 1000: x_m = 1000*D^5 C(8m,5) then >>>7
  task automatic push_step();
    push(437 + RND);
    push(31937 + RND);
    push(165812 + RND);
    push(249812 + RND);
    for (int i = 0; i < 4; i++) push(256000);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (reset_n && out_strobe) begin
        if (cyc - last_out_cyc < min_gap) min_gap = cyc - last_out_cyc;
        last_out_cyc = cyc;
        n_out++;
        if (sb_on) begin
          if (sb_q.size() == 0) begin
            n_cmp++;
            n_mis++;
            $display("FAIL unexpected_output: got out_strobe with out_data=%0d required none",
                     $signed(out_data));
          end else begin
            e = sb_q.pop_front();
            if (!e.skip) check("out_data", $signed(out_data), e.val);
          end
        end
      end
    end
  end

  task automatic do_reset(input logic [6:0] r);
    @(negedge clock);
    in_strobe = 1'b0;
    in_data   = '0;
    rate      = r;
    reset_n   = 1'b0;
    repeat (2) @(negedge clock);
    reset_n      = 1'b1;
    last_out_cyc = -1000;
  endtask

  task automatic run_dc(input int v, input int interval, input int nstrobes);
    for (int n = 0; n < nstrobes; n++) begin
      @(negedge clock);
      in_strobe = 1'b1;
      in_data   = 16'(v);
      repeat (interval - 1) begin
        @(negedge clock);
        in_strobe = 1'b0;
        in_data   = 16'h5a5a;
      end
    end
    @(negedge clock);
    in_strobe = 1'b0;
  endtask

  task automatic drain(input string name);
    int i = 0;
    while (sb_q.size() != 0 && i < 400) begin
      @(posedge clock);
      i++;
    end
    check({name, "_outputs_pending"}, sb_q.size(), 0);
    repeat (10) @(negedge clock);
  endtask

  initial begin : stimulus
    int t0, nb, i;

    #2;
    check("reset_out_data", int'(out_data), 0);
    check("reset_out_strobe", int'(out_strobe), 0);
    check("reset_overrun", int'(overrun), 0);

    // latency: rate=1 clamps to 2, isolated strobes 10 clocks apart
    do_reset(7'd1);
    push(0);
    @(negedge clock); in_strobe = 1'b1; in_data = 16'd1000;
    @(negedge clock); in_strobe = 1'b0; in_data = 16'h5a5a;
    repeat (8) @(negedge clock);
    @(negedge clock); in_strobe = 1'b1; in_data = 16'd1000;
    t0 = cyc + 1;
    nb = n_out;
    @(negedge clock); in_strobe = 1'b0; in_data = 16'h5a5a;
    i = 0;
    while (n_out == nb && i < 30) begin
      @(posedge clock);
      #2;
      i++;
    end
    check("latency", last_out_cyc - t0, 7);
    push(0); push(48000); push(208000); push(256000); push(256000);
    run_dc(1000, 10, 10);
    drain("rate2");
    check("rate2_overrun", int'(overrun), 0);

    do_reset(7'd8);
    push_step();
    run_dc(1000, 4, 64);
    drain("dc_step");
    check("dc_step_overrun", int'(overrun), 0);

    do_reset(7'd5);
    push_skip(5);
    for (int k = 0; k < 3; k++) push(24414);
    run_dc(1000, 2, 40);
    drain("rate5");
    check("rate5_overrun", int'(overrun), 0);

    do_reset(7'd64);
    push_skip(5);
    push(-8388608); push(-8388608);
    run_dc(-32768, 1, 448);
    drain("fs_neg");
    check("fs_neg_overrun", int'(overrun), 0);

    // rate=100 clamps to 64
    do_reset(7'd100);
    push_skip(5);
    push(8388352); push(8388352);
    run_dc(32767, 1, 448);
    drain("fs_pos");
    check("fs_pos_overrun", int'(overrun), 0);

    // rate change two clocks after the 3rd decimating strobe lands mid-COMB
    do_reset(7'd8);
    push(437 + RND);
    push(31937 + RND);
    push_skip(4);
    for (int k = 0; k < 3; k++) push(256000);
    nb = 0;
    for (int n = 0; n < 24 + 448; n++) begin
      @(negedge clock); in_strobe = 1'b1; in_data = 16'd1000;
      @(negedge clock); in_strobe = 1'b0; in_data = 16'h5a5a;
      @(negedge clock);
      if (n == 23) begin
        rate = 7'd64;
        nb   = n_out;
      end
      @(negedge clock);
      if (n == 28) check("aborted_output_count", n_out, nb);
    end
    @(negedge clock); in_strobe = 1'b0;
    drain("rate_change");
    check("rate_change_overrun", int'(overrun), 0);

    // continuous strobes at rate 2 overrun the comb engine
    do_reset(7'd2);
    sb_on   = 1'b0;
    min_gap = 1000;
    nb      = n_out;
    @(negedge clock); in_strobe = 1'b1; in_data = 16'd1000;
    repeat (100) @(negedge clock);
    check("overrun_set", int'(overrun), 1);
    check("overrun_outputs_seen", int'((n_out - nb) >= 10), 1);
    n_cmp++;
    if (min_gap < 7) begin
      n_mis++;
      $display("FAIL min_gap: got %0d required >= 7", min_gap);
    end
    nb = n_out;
    i  = 0;
    while (n_out == nb && i < 20) begin
      @(posedge clock);
      #2;
      i++;
    end
    repeat (3) @(posedge clock);
    #3;
    in_strobe = 1'b0;
    rate      = 7'd8;
    reset_n   = 1'b0;
    #1;
    check("midreset_out_data", int'(out_data), 0);
    check("midreset_out_strobe", int'(out_strobe), 0);
    check("midreset_overrun", int'(overrun), 0);
    repeat (2) @(negedge clock);
    reset_n      = 1'b1;
    last_out_cyc = -1000;
    sb_on        = 1'b1;
    push_step();
    run_dc(1000, 4, 64);
    drain("after_reset");
    check("after_reset_overrun", int'(overrun), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "timeout");
  end

endmodule
